// File: rtl/speaker_arbiter.sv
// rtl/speaker_arbiter.sv - round-robin arbiter sharing the speaker sample port
// between N_REQ requesters using 4-phase command/response handshakes.
module speaker_arbiter #(
    parameter int N_REQ = 2,
    parameter int GW    = 1
) (
    input  logic                  clock_25m,
    input  logic                  reset_25m_n,
    input  logic [N_REQ-1:0]      req_command,
    input  logic [32*N_REQ-1:0]   req_sample,
    output logic [N_REQ-1:0]      req_response,
    output logic                  speaker_command,
    output logic [31:0]           speaker_sample,
    input  logic                  speaker_response,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  protocol_error
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_ACK} state_t;

    state_t            r_state, w_state_nx;
    logic [N_REQ-1:0]  r_resp, w_resp_nx;
    logic              r_cmd, w_cmd_nx;
    logic [31:0]       r_sample, w_sample_nx;
    logic [GW-1:0]     r_grant, w_grant_nx;
    logic              r_err, w_err_nx;

    logic              w_found;
    logic [GW-1:0]     w_pick;
    logic [31:0]       w_pick_sample;
    logic              w_cmd_g;

    // Round-robin scan: smallest offset past the last grant wins, so walk
    // offsets downward and let the nearest candidate overwrite the rest.
    always_comb begin
        w_found       = 1'b0;
        w_pick        = '0;
        w_pick_sample = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (j == (int'(r_grant) + k) % N_REQ && req_command[j]) begin
                    w_found       = 1'b1;
                    w_pick        = GW'(j);
                    w_pick_sample = req_sample[32*j +: 32];
                end
            end
        end
    end

    assign w_cmd_g = req_command[r_grant];

    always_comb begin
        w_state_nx  = r_state;
        w_resp_nx   = r_resp;
        w_cmd_nx    = r_cmd;
        w_sample_nx = r_sample;
        w_grant_nx  = r_grant;
        w_err_nx    = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nx  = w_pick;
                    w_sample_nx = w_pick_sample;
                    w_cmd_nx    = 1'b1;
                    w_state_nx  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (speaker_response) begin
                    w_cmd_nx   = 1'b0;
                    w_state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // An early command drop is only judged here, after the speaker
                // transaction has fully completed.
                if (!speaker_response) begin
                    if (w_cmd_g) begin
                        w_resp_nx  = N_REQ'(1) << r_grant;
                        w_state_nx = S_ACK;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_ACK: begin
                if (!w_cmd_g) begin
                    w_resp_nx  = '0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            r_state  <= S_IDLE;
            r_resp   <= '0;
            r_cmd    <= 1'b0;
            r_sample <= '0;
            r_grant  <= GW'(N_REQ - 1);
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_resp   <= w_resp_nx;
            r_cmd    <= w_cmd_nx;
            r_sample <= w_sample_nx;
            r_grant  <= w_grant_nx;
            r_err    <= w_err_nx;
        end
    end

    assign req_response    = r_resp;
    assign speaker_command = r_cmd;
    assign speaker_sample  = r_sample;
    assign grant_id        = r_grant;
    assign busy            = (r_state != S_IDLE);
    assign protocol_error  = r_err;

endmodule
